// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS      = 11;
  localparam int unsigned PS2_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/ps2_fifo.sv
// Byte FIFO for received scancodes; pop on empty and push on full (without pop) are dropped.
module ps2_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_c;
  logic          do_pop_c;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign do_pop_c  = pop & ~empty;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push_c = push & (~full | do_pop_c);
  assign dout      = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with scancode FIFO and sticky error/overflow flags.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_AW = 3,
  parameter int unsigned TIMEOUT = PS2_TIMEOUT_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  input  logic       kbd_ack,
  output logic       kbd_ovf,
  output logic       kbd_err,
  input  logic       kbd_clr
);

  localparam int unsigned DATA_BITS = PS2_FRAME_BITS - 3;
  localparam int unsigned BC_W      = $clog2(DATA_BITS);
  localparam int unsigned TO_W      = $clog2(TIMEOUT) + 1;

  logic                 ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic                 ps2_dat_meta_q, ps2_dat_sync_q;
  ps2_state_e           state_q, state_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 push_q, push_d;
  logic                 kbd_err_q, kbd_err_d;
  logic                 kbd_ovf_q, kbd_ovf_d;
  logic                 fall_c, dat_c, timeout_c, frame_ok_c, err_set_c;
  logic                 fifo_empty, fifo_full;
  logic [7:0]           fifo_dout;

  assign fall_c    = ps2_clk_prev_q & ~ps2_clk_sync_q;
  assign dat_c     = ps2_dat_sync_q;
  assign timeout_c = (state_q != ST_IDLE) && !fall_c && (to_cnt_q == TO_W'(TIMEOUT - 1));

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;
  assign frame_ok_c = dat_c & (^{shift_q, parity_q});
  assign parity_d   = (fall_c && state_q == ST_PARITY) ? dat_c : parity_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`else
  assign frame_ok_c = dat_c;
`endif

  // State register plus synchronizers and datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_clk_meta_q <= 1'b1;
      ps2_clk_sync_q <= 1'b1;
      ps2_clk_prev_q <= 1'b1;
      ps2_dat_meta_q <= 1'b1;
      ps2_dat_sync_q <= 1'b1;
      state_q        <= ST_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      to_cnt_q       <= '0;
      push_q         <= 1'b0;
      kbd_err_q      <= 1'b0;
      kbd_ovf_q      <= 1'b0;
    end else begin
      ps2_clk_meta_q <= ps2_clk;
      ps2_clk_sync_q <= ps2_clk_meta_q;
      ps2_clk_prev_q <= ps2_clk_sync_q;
      ps2_dat_meta_q <= ps2_dat;
      ps2_dat_sync_q <= ps2_dat_meta_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      to_cnt_q       <= to_cnt_d;
      push_q         <= push_d;
      kbd_err_q      <= kbd_err_d;
      kbd_ovf_q      <= kbd_ovf_d;
    end
  end

  // Next-state logic; a timeout overrides any frame progress.
  always_comb begin
    state_d = state_q;
    if (timeout_c) begin
      state_d = ST_IDLE;
    end else if (fall_c) begin
      case (state_q)
        ST_IDLE:   if (!dat_c) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == BC_W'(DATA_BITS - 1)) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and flag updates; a flag set beats a same-cycle clear.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    push_d    = 1'b0;
    err_set_c = 1'b0;
    if (state_q == ST_IDLE || fall_c || timeout_c) to_cnt_d = '0;
    else                                           to_cnt_d = to_cnt_q + TO_W'(1);
    if (timeout_c) begin
      bit_cnt_d = '0;
      err_set_c = 1'b1;
    end else if (fall_c) begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = '0;
          err_set_c = dat_c;
        end
        ST_DATA: begin
          shift_d   = {dat_c, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = (bit_cnt_q == BC_W'(DATA_BITS - 1)) ? '0 : bit_cnt_q + BC_W'(1);
        end
        ST_STOP: begin
          push_d    = frame_ok_c;
          err_set_c = ~frame_ok_c;
        end
        default: ;
      endcase
    end
    kbd_err_d = err_set_c | (kbd_err_q & ~kbd_clr);
    kbd_ovf_d = (push_q & fifo_full & ~kbd_ack) | (kbd_ovf_q & ~kbd_clr);
  end

  ps2_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push_q),
    .pop   (kbd_ack),
    .din   (shift_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kbd_data  = fifo_dout;
  assign kbd_ready = ~fifo_empty;
  assign kbd_ovf   = kbd_ovf_q;
  assign kbd_err   = kbd_err_q;

endmodule
